mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store unit for the pipelined core's MEM stage: the initiator that drives the word-wide data memory port. It accepts byte, halfword and word loads and stores from the pipeline, and stalls the pipeline while it works. It performs sub-word stores as read-modify-write, because the memory has no byte enables. Loads are sign- or zero-extended, and misaligned accesses are reported as faults.

## Interface
- MEM_WORDS, 1024, data memory depth in 32-bit words (range-check bound)
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  MEM stage holds a load/store; pipeline keeps req_* stable while stall=1
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  freeze pipeline
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- misaligned  out  1  one-cycle pulse with rsp_valid: access faulted, no memory traffic
- mem_rd_en  out  1  memory read strobe
- mem_wr_en  out  1  memory write strobe
- mem_addr  out  32  word index = req_addr[31:2], zero-extended
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  memory read data; combinational, valid in the same cycle as mem_rd_en

## Operation
- States: IDLE, RD, WR, RESP. Reset drives state to IDLE and clears all request/data registers to 0.
- Outputs after reset: stall, rsp_valid, misaligned, mem_rd_en, mem_wr_en = 0; mem_addr, mem_wdata, rsp_rdata = 0.
- IDLE with req_valid=1: latch the request. Next state is:
  - RESP if the access faults;
  - WR for a word store;
  - RD for any load or a sub-word store.
- IDLE with req_valid=0: stay in IDLE.
- Fault conditions:
  - size 11;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠00.
- RD: mem_rd_en=1. Capture mem_rdata on the closing edge. Next state is RESP for a load, WR for a store.
- WR: mem_wr_en=1 for exactly one cycle.
  - Word store: mem_wdata = req_wdata.
  - Sub-word store: mem_wdata = captured word with the target lane replaced.
  - Byte lane is addr[1:0], little-endian (lane 0 = bits 7:0). Halfword lane is addr[1] (0 = bits 15:0).
  - Next state is RESP.
- RESP: rsp_valid=1 and stall=0.
  - Load data is the selected lane, sign- or zero-extended to 32 bits.
  - Next state is IDLE. A new request is sampled on the following IDLE cycle, never in RESP.
- mem_* outputs decode only from the state and latched registers; there is no combinational path from req_* to mem_*.
- mem_rd_en and mem_wr_en are never high in the same cycle. Both are low in IDLE and RESP.

## Timing
- stall = (state==IDLE & req_valid) | state==RD | state==WR. It is forced to 0 while reset=1.
- Latency from the request-accept cycle (C0) to rsp_valid, with stall high in every cycle before RESP:
  - load: RESP in C2;
  - word store: RESP in C2;
  - sub-word store: RESP in C3;
  - fault: RESP in C1.
- Back-to-back requests: one IDLE cycle separates RESP from the next accept. Throughput is at most one access per 3 cycles.
- The memory writes on negedge inside the WR cycle, so mem_addr and mem_wdata are stable for the whole WR cycle.
- Reset mid-operation:
  - Return immediately to IDLE and abandon the access.
  - If reset asserts in RD, no write follows.
  - If reset asserts in WR, the strobe drops asynchronously. The write is not guaranteed.
  - No rsp_valid pulse is produced for an abandoned access.

## Configuration
- LSU_RANGE_CHECK_EN defined: an access with req_addr[31:2] ≥ MEM_WORDS is also a fault. It behaves like a misaligned fault (RESP in C1, misaligned=1, no strobes).
- LSU_RANGE_CHECK_EN undefined: no range check. mem_addr passes through the full word index.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load 0x10 -> mem_wr_en once with mem_addr=4 and mem_wdata=0xDEADBEEF. The load returns rsp_rdata=0xDEADBEEF in C2, with stall high for 2 cycles.
- Memory word 4 = 0x11223344; byte store 0xAA to 0x12 -> RD then WR with mem_wdata=0x11AA3344. rsp_valid arrives in C3.
- Memory word 4 = 0x80FF7F01; load at 0x11:
  - signed byte -> 0x0000007F;
  - signed byte at 0x12 -> 0xFFFFFFFF;
  - unsigned halfword at 0x12 -> 0x000080FF.
- Word load at 0x13 and halfword store at 0x11 -> misaligned=1 with rsp_valid in C1, rsp_rdata=0, no mem strobes.
- Reset pulse during RD of a byte store -> state IDLE, no mem_wr_en, memory unchanged, stall=0.
- With LSU_RANGE_CHECK_EN and MEM_WORDS=1024, word load at 0x1000 -> misaligned fault. Without the macro -> mem_rd_en with mem_addr=1024.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit driving a word-wide data memory port.
// Byte/halfword/word loads (sign or zero extended) and stores; sub-word stores
// are done as read-modify-write since the memory has no byte enables.
// Misaligned or illegal-size accesses fault without touching memory.
// Optional feature macro: LSU_RANGE_CHECK_EN -- also fault when the word index
// req_addr[31:2] is at or beyond MEM_WORDS.
module mem_lsu #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misaligned,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 30;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

`ifdef LSU_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                req_we_q, req_we_d;
  logic [1:0]          req_size_q, req_size_d;
  logic                req_uns_q, req_uns_d;
  logic [1:0]          req_lane_q, req_lane_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                misaligned_q, misaligned_d;

  logic                align_fault_c;
  logic                range_fault_c;
  logic                fault_c;

  // Extract the addressed lane of a memory word and extend it to 32 bits
  function automatic logic [DATA_W-1:0] extend_load(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        size,
    input logic              uns,
    input logic [1:0]        lane
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SIZE_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of a memory word with right-justified store data
  function automatic logic [DATA_W-1:0] merge_store(
    input logic [DATA_W-1:0] word,
    input logic [DATA_W-1:0] data,
    input logic [1:0]        size,
    input logic [1:0]        lane
  );
    logic [DATA_W-1:0] r;
    r = word;
    case (size)
      SIZE_BYTE: r[{lane, 3'b000} +: 8] = data[7:0];
      SIZE_HALF: begin
        if (lane[1]) r[31:16] = data[15:0];
        else         r[15:0]  = data[15:0];
      end
      default:   r = data;
    endcase
    return r;
  endfunction

  // Fault detection on the incoming request (only consulted when accepting in IDLE)
  always_comb begin
    align_fault_c = (req_size == 2'b11)
                  | ((req_size == SIZE_HALF) & req_addr[0])
                  | ((req_size == SIZE_WORD) & (req_addr[1:0] != 2'b00));
    range_fault_c = RANGE_CHECK
                  & ({2'b00, req_addr[31:2]} >= DATA_W'(MEM_WORDS));
    fault_c       = align_fault_c | range_fault_c;
  end

  // Pipeline freeze: request waiting in IDLE, or memory phase in progress
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      stall = ((state_q == IDLE) & req_valid) | (state_q == RD) | (state_q == WR);
    end
  end

  // Next-state and next-output decode; all outputs come from the registers below
  always_comb begin
    state_d      = state_q;
    req_we_d     = req_we_q;
    req_size_d   = req_size_q;
    req_uns_d    = req_uns_q;
    req_lane_d   = req_lane_q;
    req_wdata_d  = req_wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rd_en_d  = 1'b0;
    mem_wr_en_d  = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = '0;
    misaligned_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_we_d    = req_we;
          req_size_d  = req_size;
          req_uns_d   = req_unsigned;
          req_lane_d  = req_addr[1:0];
          req_wdata_d = req_wdata;
          mem_addr_d  = {2'b00, IDX_W'(req_addr[31:2])};
          if (fault_c) begin
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            misaligned_d = 1'b1;
          end else if (req_we && (req_size == SIZE_WORD)) begin
            state_d     = WR;
            mem_wr_en_d = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d     = RD;
            mem_rd_en_d = 1'b1;
          end
        end
      end

      RD: begin
        if (req_we_q) begin
          state_d     = WR;
          mem_wr_en_d = 1'b1;
          mem_wdata_d = merge_store(mem_rdata, req_wdata_q, req_size_q, req_lane_q);
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = extend_load(mem_rdata, req_size_q, req_uns_q, req_lane_q);
        end
      end

      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_we_q     <= 1'b0;
      req_size_q   <= 2'b00;
      req_uns_q    <= 1'b0;
      req_lane_q   <= 2'b00;
      req_wdata_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rd_en_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_we_q     <= req_we_d;
      req_size_q   <= req_size_d;
      req_uns_q    <= req_uns_d;
      req_lane_q   <= req_lane_d;
      req_wdata_q  <= req_wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_wr_en_q  <= mem_wr_en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign mem_rd_en  = mem_rd_en_q;
  assign mem_wr_en  = mem_wr_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: table-driven bench for mem_lsu with a 1024-word memory model
// that reads combinationally and writes on negedge.
module tb_mem_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misaligned;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  mem_lsu #(.MEM_WORDS(1024)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .misaligned   (misaligned),
    .mem_rd_en    (mem_rd_en),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'd0;

  always @(negedge clk) begin
    if (mem_wr_en && (mem_addr < 32'd1024)) mem[mem_addr[9:0]] <= mem_wdata;
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          rd;
    int          wr;
    logic        fault;
    logic [31:0] rdata;
    logic [31:0] wword;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int          r_lat, r_rd, r_wr, r_both, r_stall_hi;
  logic        r_stall_resp, r_fault, r_timeout, r_gap_rsp;
  logic [31:0] r_rdata, r_last_addr, r_last_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one request in an IDLE cycle and record what the DUT does until rsp_valid
  task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bit done;
    r_lat = 0; r_rd = 0; r_wr = 0; r_both = 0; r_stall_hi = 0;
    r_stall_resp = 1'b1; r_fault = 1'b0; r_rdata = 32'hx;
    r_last_addr = 32'hx; r_last_wdata = 32'hx;
    done = 1'b0;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    #1;
    if (stall) r_stall_hi++;
    for (int c = 1; c <= 8 && !done; c++) begin
      @(negedge clk);
      if (mem_rd_en) begin r_rd++; r_last_addr = mem_addr; end
      if (mem_wr_en) begin r_wr++; r_last_addr = mem_addr; r_last_wdata = mem_wdata; end
      if (mem_rd_en && mem_wr_en) r_both++;
      if (rsp_valid) begin
        done = 1'b1; r_lat = c; r_rdata = rsp_rdata;
        r_fault = misaligned; r_stall_resp = stall;
      end else if (stall) begin
        r_stall_hi++;
      end
    end
    req_valid = 1'b0;
    r_timeout = !done;
    @(negedge clk);
    r_gap_rsp = rsp_valid;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    do_access(v.we, v.size, v.uns, v.addr, v.wdata);
    check({tag, "_timeout"}, 32'(r_timeout), 32'd0);
    check({tag, "_latency"}, 32'(r_lat), 32'(v.lat));
    check({tag, "_rd_count"}, 32'(r_rd), 32'(v.rd));
    check({tag, "_wr_count"}, 32'(r_wr), 32'(v.wr));
    check({tag, "_rd_wr_overlap"}, 32'(r_both), 32'd0);
    check({tag, "_misaligned"}, 32'(r_fault), 32'(v.fault));
    check({tag, "_rsp_rdata"}, r_rdata, v.rdata);
    check({tag, "_stall_cycles"}, 32'(r_stall_hi), 32'(v.lat));
    check({tag, "_stall_in_resp"}, 32'(r_stall_resp), 32'd0);
    check({tag, "_rsp_one_cycle"}, 32'(r_gap_rsp), 32'd0);
    if (v.rd + v.wr > 0) check({tag, "_mem_addr"}, r_last_addr, v.addr >> 2);
    if (v.wr > 0) begin
      check({tag, "_mem_wdata"}, r_last_wdata, v.wword);
      check({tag, "_mem_word"}, mem[10'(v.addr >> 2)], v.wword);
    end
  endtask

  initial begin
    int wr_seen, rsp_seen;

    //           we    size   uns   addr         wdata         lat rd wr fault rdata         wword
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 2, 0, 1, 1'b0, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        2, 1, 0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'h11223344, 2, 0, 1, 1'b0, 32'h0,        32'h11223344};
    vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h12,   32'h000000AA, 3, 1, 1, 1'b0, 32'h0,        32'h11AA3344};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        2, 1, 0, 1'b0, 32'h11AA3344, 32'h0};
    vecs[5]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'h80FF7F01, 2, 0, 1, 1'b0, 32'h0,        32'h80FF7F01};
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h11,   32'h0,        2, 1, 0, 1'b0, 32'h0000007F, 32'h0};
    vecs[7]  = '{1'b0, 2'b00, 1'b0, 32'h12,   32'h0,        2, 1, 0, 1'b0, 32'hFFFFFFFF, 32'h0};
    vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h12,   32'h0,        2, 1, 0, 1'b0, 32'h000080FF, 32'h0};
    vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h12,   32'h0,        2, 1, 0, 1'b0, 32'hFFFF80FF, 32'h0};
    vecs[10] = '{1'b0, 2'b00, 1'b1, 32'h13,   32'h0,        2, 1, 0, 1'b0, 32'h00000080, 32'h0};
    vecs[11] = '{1'b0, 2'b01, 1'b0, 32'h10,   32'h0,        2, 1, 0, 1'b0, 32'h00007F01, 32'h0};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h13,   32'h0,        1, 0, 0, 1'b1, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h11,   32'h0000CAFE, 1, 0, 0, 1'b1, 32'h0,        32'h0};
    vecs[14] = '{1'b0, 2'b11, 1'b0, 32'h10,   32'h0,        1, 0, 0, 1'b1, 32'h0,        32'h0};
    vecs[15] = '{1'b1, 2'b01, 1'b0, 32'h12,   32'h1234BEEF, 3, 1, 1, 1'b0, 32'h0,        32'hBEEF7F01};
    vecs[16] = '{1'b1, 2'b00, 1'b0, 32'h10,   32'hFFFFFF55, 3, 1, 1, 1'b0, 32'h0,        32'hBEEF7F55};
    vecs[17] = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        2, 1, 0, 1'b0, 32'hBEEF7F55, 32'h0};
    vecs[18] = '{1'b1, 2'b10, 1'b0, 32'h12,   32'h01020304, 1, 0, 0, 1'b1, 32'h0,        32'h0};
    vecs[19] = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        2, 1, 0, 1'b0, 32'hBEEF7F55, 32'h0};
`ifdef LSU_RANGE_CHECK_EN
    vecs[20] = '{1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,        1, 0, 0, 1'b1, 32'h0,        32'h0};
`else
    vecs[20] = '{1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,        2, 1, 0, 1'b0, 32'h0,        32'h0};
`endif

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);

    // Reset values, and stall held low while reset is asserted
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    req_valid = 1'b1;
    #1;
    check("rst_stall_forced_low", 32'(stall), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) apply_vec(i, vecs[i]);

    // Reset during RD of a byte store: abandoned, no write, memory intact
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h00000033;
    @(negedge clk);
    check("rstrd_in_rd", 32'(mem_rd_en), 32'd1);
    reset = 1'b1;
    #1;
    check("rstrd_stall", 32'(stall), 32'd0);
    check("rstrd_rd_drop", 32'(mem_rd_en), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wr_seen = 0; rsp_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_wr_en) wr_seen++;
      if (rsp_valid) rsp_seen++;
    end
    check("rstrd_no_write", 32'(wr_seen), 32'd0);
    check("rstrd_no_rsp", 32'(rsp_seen), 32'd0);
    check("rstrd_mem_word", mem[4], 32'hBEEF7F55);
    check("rstrd_stall_idle", 32'(stall), 32'd0);

    // Reset during WR of a word store: strobe drops at once, no response
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(negedge clk);
    check("rstwr_in_wr", 32'(mem_wr_en), 32'd1);
    reset = 1'b1;
    #1;
    check("rstwr_wr_drop", 32'(mem_wr_en), 32'd0);
    check("rstwr_stall", 32'(stall), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rsp_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    check("rstwr_no_rsp", 32'(rsp_seen), 32'd0);

    // Normal operation resumes after the abandoned accesses
    apply_vec(100, vecs[19]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
